// File: rtl/mac_seq_28_pkg.sv
// Shared definitions for the mac_seq_28 operand sequencer: FSM encoding,
// default geometry and a packed-vector width helper.
package mac_seq_28_pkg;

  localparam int LANES_DEF = 28;
  localparam int DW_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FEED    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RESCALE = 3'd4
  } state_e;

  function automatic int vec_width(input int lanes, input int dw);
    return lanes * dw;
  endfunction

endpackage

// File: rtl/mac_operand_reg.sv
// One registered operand bus for the MAC array: loads a full vector or
// zero-fills it so that idle cycles accumulate nothing.
module mac_operand_reg #(
  parameter int W = 224
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         zero_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i)      q_d = d_i;
    else if (zero_i) q_d = '0;
  end

  // NOTE: state registers take non-blocking assignments and are reset, since
  // these bits feed the MAC array directly and must be 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mac_seq_28.sv
// Operand sequencer for the 28-lane int8 MAC array: clears the accumulators,
// feeds K jointly-handshaken A/B beats, drains the pipeline, then rescales.
module mac_seq_28
  import mac_seq_28_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int KW    = 16,
  parameter int DRAIN = 1
) (
  input  logic                  clk,
  input  logic                  main_rst,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  a_valid,
  input  logic [LANES*DW-1:0]   a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [LANES*DW-1:0]   b_data,
  output logic                  b_ready,
  output logic [LANES*DW-1:0]   A_bus,
  output logic [LANES*DW-1:0]   B_bus,
  output logic                  mac_rst,
  output logic                  rescale,
  output logic                  busy,
  output logic                  done
);

  localparam int         VW         = vec_width(LANES, DW);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic [3:0]      drain_q, drain_d;
  logic            mac_rst_q, mac_rst_d;
  logic            rescale_q, rescale_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            beat;
  logic            last_beat;

  // A beat needs both streams at once; neither side is ever consumed alone.
  assign beat      = (state_q == ST_FEED) && a_valid && b_valid;
  assign last_beat = beat && (cnt_q == k_q - KW'(1));
  assign a_ready   = beat;
  assign b_ready   = beat;

  always_ff @(posedge clk or negedge main_rst) begin
    if (!main_rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      drain_q   <= '0;
      mac_rst_q <= 1'b0;
      rescale_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      mac_rst_q <= mac_rst_d;
      rescale_q <= rescale_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The first DRAIN-state cycle presents the final operand to the array;
  // DRAIN further zero cycles follow before the rescale strobe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = (k_len == '0) ? ST_RESCALE : ST_CLEAR;
      ST_CLEAR:   state_d = ST_FEED;
      ST_FEED:    if (last_beat) state_d = ST_DRAIN;
      ST_DRAIN:   if (drain_q == DRAIN_LAST) state_d = ST_RESCALE;
      ST_RESCALE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no latch forms.
  always_comb begin
    k_d       = k_q;
    cnt_d     = cnt_q;
    drain_d   = '0;
    mac_rst_d = (state_d == ST_CLEAR);
    rescale_d = (state_d == ST_RESCALE);
    done_d    = (state_d == ST_RESCALE);
    busy_d    = (state_d != ST_IDLE);
    if (state_q == ST_IDLE && start) begin
      k_d   = k_len;
      cnt_d = '0;
    end
    if (beat) cnt_d = cnt_q + KW'(1);
    if (state_q == ST_DRAIN) drain_d = drain_q + 4'd1;
  end

  mac_operand_reg #(.W(VW)) u_a_reg (
    .clk    (clk),
    .rst_n  (main_rst),
    .load_i (beat),
    .zero_i (!beat),
    .d_i    (a_data),
    .q_o    (A_bus)
  );

  mac_operand_reg #(.W(VW)) u_b_reg (
    .clk    (clk),
    .rst_n  (main_rst),
    .load_i (beat),
    .zero_i (!beat),
    .d_i    (b_data),
    .q_o    (B_bus)
  );

  assign mac_rst = mac_rst_q;
  assign rescale = rescale_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mac_seq_28.sv
// Directed bench for mac_seq_28: cycle tables for the DRAIN=1 instance plus
// hand sequences for mid-job reset and lane mapping on a DRAIN=0 instance.
module tb_mac_seq_28;

  localparam int LANES = 28;
  localparam int DW    = 8;
  localparam int KW    = 16;
  localparam int VW    = LANES * DW;

  typedef struct {
    logic          st;
    logic [KW-1:0] k;
    logic          av, bv;
    logic [7:0]    a, b;
    logic          e_mr, e_rdy, e_rs, e_busy;
    logic [7:0]    e_a, e_b;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          main_rst, start, start0, a_valid, b_valid;
  logic [KW-1:0] k_len;
  logic [VW-1:0] a_data, b_data;
  logic          a_ready, b_ready, mac_rst, rescale, busy, done;
  logic [VW-1:0] A_bus, B_bus;
  logic          a_ready0, b_ready0, mac_rst0, rescale0, busy0, done0;
  logic [VW-1:0] A_bus0, B_bus0;

  mac_seq_28 #(.DRAIN(1)) dut (
    .clk(clk), .main_rst(main_rst), .start(start), .k_len(k_len),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .A_bus(A_bus), .B_bus(B_bus), .mac_rst(mac_rst), .rescale(rescale),
    .busy(busy), .done(done)
  );

  mac_seq_28 #(.DRAIN(0)) dut0 (
    .clk(clk), .main_rst(main_rst), .start(start0), .k_len(k_len),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready0),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready0),
    .A_bus(A_bus0), .B_bus(B_bus0), .mac_rst(mac_rst0), .rescale(rescale0),
    .busy(busy0), .done(done0)
  );

  int checks = 0;
  int errors = 0;
  row_t rows[$];

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep(input logic [7:0] v);
    return {LANES{v}};
  endfunction

  function automatic row_t mk(input logic st, input int k, input logic av, input logic bv,
                              input int a, input int b, input logic mr, input logic rdy,
                              input logic rs, input logic bz, input int ea, input int eb);
    row_t r;
    r.st = st; r.k = KW'(k); r.av = av; r.bv = bv; r.a = 8'(a); r.b = 8'(b);
    r.e_mr = mr; r.e_rdy = rdy; r.e_rs = rs; r.e_busy = bz; r.e_a = 8'(ea); r.e_b = 8'(eb);
    return r;
  endfunction

  // Entry and exit are 1 time unit after a rising edge; each row is one cycle.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      start   = rows[i].st;
      k_len   = rows[i].k;
      a_valid = rows[i].av;
      b_valid = rows[i].bv;
      a_data  = rep(rows[i].a);
      b_data  = rep(rows[i].b);
      #1;
      check($sformatf("r%0d mac_rst", i), VW'(mac_rst), VW'(rows[i].e_mr));
      check($sformatf("r%0d a_ready", i), VW'(a_ready), VW'(rows[i].e_rdy));
      check($sformatf("r%0d b_ready", i), VW'(b_ready), VW'(rows[i].e_rdy));
      check($sformatf("r%0d rescale", i), VW'(rescale), VW'(rows[i].e_rs));
      check($sformatf("r%0d done", i), VW'(done), VW'(rows[i].e_rs));
      check($sformatf("r%0d busy", i), VW'(busy), VW'(rows[i].e_busy));
      check($sformatf("r%0d A_bus", i), A_bus, rep(rows[i].e_a));
      check($sformatf("r%0d B_bus", i), B_bus, rep(rows[i].e_b));
      @(posedge clk); #1;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int s_basic, s_stall, s_zero, s_ign, s_r1, s_r2, s_end;
    logic [VW-1:0] lane_a, lane_b;
    logic [7:0]    l0, l27;

    s_basic = rows.size();
    rows.push_back(mk(1,3,1,1,1,2, 0,0,0,0,0,0));
    rows.push_back(mk(0,0,1,1,1,2, 1,0,0,1,0,0));
    rows.push_back(mk(0,0,1,1,1,2, 0,1,0,1,0,0));
    rows.push_back(mk(0,0,1,1,2,2, 0,1,0,1,1,2));
    rows.push_back(mk(0,0,1,1,3,2, 0,1,0,1,2,2));
    rows.push_back(mk(0,0,1,1,9,9, 0,0,0,1,3,2));
    rows.push_back(mk(0,0,0,0,0,0, 0,0,0,1,0,0));
    rows.push_back(mk(0,0,0,0,0,0, 0,0,1,1,0,0));
    rows.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
    s_stall = rows.size();
    rows.push_back(mk(1,2,1,1,4,5, 0,0,0,0,0,0));
    rows.push_back(mk(0,2,1,1,4,5, 1,0,0,1,0,0));
    rows.push_back(mk(0,2,1,1,4,5, 0,1,0,1,0,0));
    rows.push_back(mk(0,2,1,0,6,7, 0,0,0,1,4,5));
    rows.push_back(mk(0,2,1,0,6,7, 0,0,0,1,0,0));
    rows.push_back(mk(0,2,1,1,6,7, 0,1,0,1,0,0));
    rows.push_back(mk(0,2,0,0,0,0, 0,0,0,1,6,7));
    rows.push_back(mk(0,2,0,0,0,0, 0,0,0,1,0,0));
    rows.push_back(mk(0,2,0,0,0,0, 0,0,1,1,0,0));
    rows.push_back(mk(0,2,0,0,0,0, 0,0,0,0,0,0));
    s_zero = rows.size();
    rows.push_back(mk(1,0,1,1,5,5, 0,0,0,0,0,0));
    rows.push_back(mk(1,0,1,1,5,5, 0,0,1,1,0,0));
    rows.push_back(mk(0,0,1,1,5,5, 0,0,0,0,0,0));
    s_ign = rows.size();
    rows.push_back(mk(1,2,1,1,1,1, 0,0,0,0,0,0));
    rows.push_back(mk(0,2,0,0,0,0, 1,0,0,1,0,0));
    rows.push_back(mk(1,5,1,1,1,1, 0,1,0,1,0,0));
    rows.push_back(mk(0,5,1,1,2,2, 0,1,0,1,1,1));
    rows.push_back(mk(0,5,1,1,3,3, 0,0,0,1,2,2));
    rows.push_back(mk(0,5,0,0,0,0, 0,0,0,1,0,0));
    rows.push_back(mk(0,5,0,0,0,0, 0,0,1,1,0,0));
    rows.push_back(mk(0,5,0,0,0,0, 0,0,0,0,0,0));
    s_r1 = rows.size();
    rows.push_back(mk(1,4,1,1,8,9, 0,0,0,0,0,0));
    rows.push_back(mk(0,4,0,0,0,0, 1,0,0,1,0,0));
    rows.push_back(mk(0,4,1,1,8,9, 0,1,0,1,0,0));
    s_r2 = rows.size();
    rows.push_back(mk(1,1,1,1,3,4, 0,0,0,0,0,0));
    rows.push_back(mk(0,1,1,1,3,4, 1,0,0,1,0,0));
    rows.push_back(mk(0,1,1,1,3,4, 0,1,0,1,0,0));
    rows.push_back(mk(0,1,1,1,7,7, 0,0,0,1,3,4));
    rows.push_back(mk(0,1,0,0,0,0, 0,0,0,1,0,0));
    rows.push_back(mk(0,1,0,0,0,0, 0,0,1,1,0,0));
    rows.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0));
    s_end = rows.size();

    main_rst = 1'b0; start = 1'b0; start0 = 1'b0; k_len = '0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", VW'(busy), '0);
    check("rst mac_rst", VW'(mac_rst), '0);
    check("rst rescale", VW'(rescale), '0);
    check("rst done", VW'(done), '0);
    check("rst A_bus", A_bus, '0);
    check("rst B_bus", B_bus, '0);
    check("rst busy0", VW'(busy0), '0);
    main_rst = 1'b1;
    tick();

    run_rows(s_basic, s_stall);
    run_rows(s_stall, s_zero);
    run_rows(s_zero, s_ign);
    run_rows(s_ign, s_r1);

    // Mid-job reset after the first of four beats.
    run_rows(s_r1, s_r2);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("pre_rst A_bus", A_bus, rep(8'd8));
    check("pre_rst busy", VW'(busy), VW'(1'b1));
    main_rst = 1'b0;
    #1;
    check("mid_rst busy", VW'(busy), '0);
    check("mid_rst A_bus", A_bus, '0);
    check("mid_rst B_bus", B_bus, '0);
    check("mid_rst a_ready", VW'(a_ready), '0);
    check("mid_rst b_ready", VW'(b_ready), '0);
    check("mid_rst mac_rst", VW'(mac_rst), '0);
    check("mid_rst rescale", VW'(rescale), '0);
    check("mid_rst done", VW'(done), '0);
    tick();
    check("in_rst busy", VW'(busy), '0);
    main_rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    run_rows(s_r2, s_end);

    // Lane mapping on the DRAIN=0 instance.
    for (int i = 0; i < LANES; i++) begin
      lane_a[i*DW +: DW] = 8'(i - 14);
      lane_b[i*DW +: DW] = 8'(3 * i + 1);
    end
    start0 = 1'b1; k_len = KW'(1);
    a_valid = 1'b1; b_valid = 1'b1; a_data = lane_a; b_data = lane_b;
    tick();
    start0 = 1'b0;
    check("lane c1 mac_rst0", VW'(mac_rst0), VW'(1'b1));
    tick();
    check("lane c2 a_ready0", VW'(a_ready0), VW'(1'b1));
    tick();
    l0 = A_bus0[0 +: DW];
    l27 = A_bus0[27*DW +: DW];
    check("lane c3 A_bus0", A_bus0, lane_a);
    check("lane c3 B_bus0", B_bus0, lane_b);
    check("lane c3 A lane0", VW'(l0), VW'(8'hF2));
    check("lane c3 A lane27", VW'(l27), VW'(8'h0D));
    check("lane c3 rescale0", VW'(rescale0), '0);
    check("lane c3 a_ready0", VW'(a_ready0), '0);
    tick();
    check("lane c4 rescale0", VW'(rescale0), VW'(1'b1));
    check("lane c4 done0", VW'(done0), VW'(1'b1));
    check("lane c4 A_bus0", A_bus0, '0);
    tick();
    check("lane c5 busy0", VW'(busy0), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
